// File: rtl/iterative_shift_unit_pkg.sv
// Shared encodings for the iterative shift unit.
// Operation and FSM state types used by the top and the step logic.
package iterative_shift_unit_pkg;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,
    OP_SHR = 2'b01,
    OP_SAR = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shift_unit_shift_step.sv
// Single 1-bit shift/rotate step, purely combinational.
// SHL path matches the upstream left-shift compute stage.
module shift_step
  import iterative_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  op_e              op,
  output logic [WIDTH-1:0] r_next,
  output logic             out
);

  always_comb begin
    r_next = {r[WIDTH-2:0], 1'b0};
    out    = r[WIDTH-1];
    case (op)
      OP_SHR: begin
        r_next = {1'b0, r[WIDTH-1:1]};
        out    = r[0];
      end
      OP_SAR: begin
        r_next = {r[WIDTH-1], r[WIDTH-1:1]};
        out    = r[0];
      end
      OP_ROL: begin
        r_next = {r[WIDTH-2:0], r[WIDTH-1]};
        out    = r[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: one 1-bit step per clock, N times,
// with carry/zero flags and a one-cycle done pulse.
module iterative_shift_unit
  import iterative_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] Result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state, state_n;
  op_e              op_r, op_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_sat;
  logic [WIDTH-1:0] res_n, step_r;
  logic             carry_n, step_out;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r     (Result),
    .op    (op_r),
    .r_next(step_r),
    .out   (step_out)
  );

  assign cnt_sat = (count > CNT_MAX) ? CNT_MAX : count;
  assign busy    = (state == ST_SHIFT);
  assign done    = (state == ST_DONE);
  assign zero    = (Result == '0);

  always_comb begin
    state_n = state;
    op_n    = op_r;
    cnt_n   = cnt;
    res_n   = Result;
    carry_n = carry;
    case (state)
      ST_IDLE: begin
        if (start) begin
          res_n   = A;
          op_n    = op_e'(op);
          carry_n = 1'b0;
          cnt_n   = cnt_sat;
          state_n = (cnt_sat == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_n   = step_r;
        carry_n = step_out;
        cnt_n   = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_n = ST_DONE;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_SHL;
      cnt    <= '0;
      Result <= '0;
      carry  <= 1'b0;
    end else begin
      state  <= state_n;
      op_r   <= op_n;
      cnt    <= cnt_n;
      Result <= res_n;
      carry  <= carry_n;
    end
  end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit.
// Hand-computed vectors, latency, busy length and pulse checks.
module tb_iterative_shift_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] A = 8'h00;
  logic [3:0] count = 4'd0;
  logic [1:0] op = 2'b00;
  logic [7:0] Result;
  logic       carry, zero, busy, done;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] trace[8];
  int         ntrace = 0;
  bit         poke = 1'b0;

  always #5 clk = ~clk;

  iterative_shift_unit #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .count (count),
    .op    (op),
    .Result(Result),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [3:0] c, input logic [1:0] o,
                        input logic [7:0] er, input logic ec,
                        input int elat);
    int lat = 0;
    int nbusy = 0;
    int ndone = 0;
    A = a;
    count = c;
    op = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    count = 4'd0;
    op = o ^ 2'b01;
    if (busy) nbusy++;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke && lat == 1) begin
        start = 1'b1;
        A = 8'h55;
        count = 4'd2;
      end
      if (poke && lat == 2) start = 1'b0;
      if (lat <= ntrace)
        check($sformatf("%s_step%0d", tag, lat), 32'(Result),
              32'(trace[lat-1]));
      if (busy) nbusy++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, nbusy, elat);
    check({tag, "_res"}, 32'(Result), 32'(er));
    check({tag, "_carry"}, 32'(carry), 32'(ec));
    check({tag, "_zero"}, 32'(zero), 32'(er == 8'h00));
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check({tag, "_pulse"}, ndone, 0);
    check({tag, "_hold"}, {Result, 7'd0, carry}, {er, 7'd0, ec});
  endtask

  initial begin
    int nd;
    #3;
    check("rst_res", 32'(Result), 32'h00);
    check("rst_flags", {carry, zero, busy, done}, 4'b0100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("shl1", 8'h81, 4'd1, 2'b00, 8'h02, 1'b1, 1);

    trace[0] = 8'h4B;
    trace[1] = 8'h25;
    trace[2] = 8'h12;
    ntrace = 3;
    run_op("shr3", 8'h96, 4'd3, 2'b01, 8'h12, 1'b1, 3);
    ntrace = 0;

    run_op("sar_sat", 8'h80, 4'd15, 2'b10, 8'hFF, 1'b1, 8);
    run_op("cnt0", 8'h00, 4'd0, 2'b00, 8'h00, 1'b0, 0);

    poke = 1'b1;
    run_op("rol4", 8'h81, 4'd4, 2'b11, 8'h18, 1'b0, 4);
    poke = 1'b0;

    run_op("rol8", 8'hA5, 4'd8, 2'b11, 8'hA5, 1'b1, 8);
    run_op("shr8", 8'h01, 4'd8, 2'b01, 8'h00, 1'b0, 8);

    A = 8'hFF;
    count = 4'd8;
    op = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", 32'(Result), 32'h00);
    check("arst_flags", {carry, zero, busy, done}, 4'b0100);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("arst_nodone", nd, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 8'h01, 4'd2, 2'b00, 8'h04, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
